yconf_loader: RTL and testbench

- Clocked configuration sequencer for a Morphle Logic cell array of BLOCKWIDTH columns by BLOCKHEIGHT rows, with CBITS configuration bits per cell.
- Generalises the fixed 3-bit per-cell shift chain: loads a whole array from a valid/ready word stream and drives one column bit per cell column on each shift.
- In SWAP mode it also returns the previous configuration shifted out at the bottom of the chain.
- Sits between the host configuration port and the top edge of a yblock array; holds the array in reset while loading.

---
 rtl/yconf_loader_pkg.sv | 31 +++
 rtl/yconf_loader_if.sv | 21 ++
 rtl/yconf_outreg.sv | 44 ++++
 rtl/yconf_loader.sv | 155 +++++++++++++++
 tb/tb_yconf_loader.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/yconf_loader_pkg.sv
// Shared types and helpers for the Morphle Logic configuration loader.
package yconf_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      HOLD  = 2'd2,
      ABORT = 2'd3
   } state_e;

   function automatic int total_f(input int h, input int c);
      return h * c;
   endfunction

   function automatic int cnt_w_f(input int h, input int c);
      return $clog2(h * c + 1);
   endfunction

   localparam int CFG_BITS = 3;

   // Per-cell configuration encodings
   localparam logic [CFG_BITS-1:0] CFG_SPACE = 3'd0;
   localparam logic [CFG_BITS-1:0] CFG_PLUS  = 3'd1;
   localparam logic [CFG_BITS-1:0] CFG_MINUS = 3'd2;
   localparam logic [CFG_BITS-1:0] CFG_BAR   = 3'd3;
   localparam logic [CFG_BITS-1:0] CFG_ONE   = 3'd4;
   localparam logic [CFG_BITS-1:0] CFG_ZERO  = 3'd5;
   localparam logic [CFG_BITS-1:0] CFG_YES   = 3'd6;
   localparam logic [CFG_BITS-1:0] CFG_NO    = 3'd7;

endpackage

// File: rtl/yconf_loader_if.sv
// Word stream in (host to loader) and readback stream out (loader to host).
interface yconf_loader_if #(
   parameter int W = 8
) ();
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/yconf_outreg.sv
// Single-entry valid/ready output register, holds data under backpressure.
module yconf_outreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/yconf_loader.sv
// Loads a BLOCKWIDTH x BLOCKHEIGHT cell array config chain from a word stream,
// optionally returning the previous configuration shifted out at the bottom.
module yconf_loader
   import yconf_loader_pkg::*;
#(
   parameter int BLOCKWIDTH  = 8,
   parameter int BLOCKHEIGHT = 8,
   parameter int CBITS       = 3,
   parameter int RELEASE     = 4
) (
   input  logic                  confclk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  swap,
   input  logic                  abort,
   yconf_loader_if.slave         strm,
   output logic [BLOCKWIDTH-1:0] arr_cbit,
   output logic                  arr_shift,
   input  logic [BLOCKWIDTH-1:0] arr_cbitret,
   output logic                  arr_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted
);

   localparam int TOTAL = total_f(BLOCKHEIGHT, CBITS);
   localparam int CW    = cnt_w_f(BLOCKHEIGHT, CBITS);
   localparam int HW    = $clog2(RELEASE + 1);

   localparam logic [CW-1:0] TOTAL_C  = CW'(TOTAL);
   localparam logic [HW-1:0] REL_LAST = HW'(RELEASE - 1);

   state_e                state_q, state_d;
   logic                  mode_q, mode_d;
   logic [CW-1:0]         count_q, count_d;
   logic [HW-1:0]         hold_q, hold_d;
   logic [BLOCKWIDTH-1:0] cbit_q, cbit_d;
   logic                  shift_q, shift_d;
   logic                  arst_q, arst_d;
   logic                  done_q, done_d;
   logic                  abrt_q, abrt_d;

   logic ov;
   logic slot_free;
   logic in_ready_c;
   logic accept;
   logic abort_go;
   logic hold_exit;
   logic flush;

   // A shift already in flight claims the slot for the next cycle
   assign slot_free  = ~(shift_q & mode_q) & (~ov | strm.out_ready);
   assign in_ready_c = (state_q == LOAD) & ~abort & (count_q < TOTAL_C)
                     & (~mode_q | slot_free);
   assign accept     = strm.in_valid & in_ready_c;
   assign abort_go   = abort & ((state_q == LOAD) | (state_q == HOLD));
   assign hold_exit  = (state_q == HOLD) & ~abort & (hold_q == REL_LAST)
                     & (~mode_q | ~ov);
   assign flush      = abort_go | (state_q == ABORT);

   always_ff @(posedge confclk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = LOAD;
         LOAD: begin
            if (abort)
               state_d = ABORT;
            else if ((count_q == TOTAL_C) && !shift_q)
               state_d = HOLD;
         end
         HOLD: begin
            if (abort)          state_d = ABORT;
            else if (hold_exit) state_d = IDLE;
         end
         ABORT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mode_d  = mode_q;
      count_d = count_q;
      cbit_d  = cbit_q;
      shift_d = accept;
      arst_d  = arst_q;
      done_d  = 1'b0;
      abrt_d  = (state_q == ABORT);
      hold_d  = '0;
      if (state_q == HOLD)
         hold_d = (hold_q == REL_LAST) ? hold_q : hold_q + HW'(1);
      if ((state_q == IDLE) && start) begin
         mode_d  = swap;
         count_d = '0;
         arst_d  = 1'b1;
      end
      if (accept) begin
         cbit_d  = strm.in_data;
         count_d = count_q + CW'(1);
      end
      if (hold_exit) begin
         arst_d = 1'b0;
         done_d = 1'b1;
      end
   end

   always_ff @(posedge confclk) begin
      if (!reset) begin
         mode_q  <= 1'b0;
         count_q <= '0;
         hold_q  <= '0;
         cbit_q  <= '0;
         shift_q <= 1'b0;
         arst_q  <= 1'b0;
         done_q  <= 1'b0;
         abrt_q  <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         count_q <= count_d;
         hold_q  <= hold_d;
         cbit_q  <= cbit_d;
         shift_q <= shift_d;
         arst_q  <= arst_d;
         done_q  <= done_d;
         abrt_q  <= abrt_d;
      end
   end

   yconf_outreg #(
      .W(BLOCKWIDTH)
   ) u_outreg (
      .clk       (confclk),
      .rst_n     (reset),
      .flush     (flush),
      .load      (shift_q & mode_q),
      .load_data (arr_cbitret),
      .out_ready (strm.out_ready),
      .out_valid (ov),
      .out_data  (strm.out_data)
   );

   assign strm.in_ready  = in_ready_c;
   assign strm.out_valid = ov;
   assign arr_cbit       = cbit_q;
   assign arr_shift      = shift_q;
   assign arr_reset      = arst_q;
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign aborted        = abrt_q;

endmodule

// File: tb/tb_yconf_loader.sv
// Directed bench for yconf_loader on a 4x2 array with a 3-bit cell chain.
module tb_yconf_loader;

   localparam int W   = 4;
   localparam int H   = 2;
   localparam int CB  = 3;
   localparam int REL = 4;
   localparam int TOT = H * CB;

   logic confclk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic swap = 1'b0;
   logic abort = 1'b0;
   logic [W-1:0] arr_cbit;
   logic [W-1:0] arr_cbitret;
   logic arr_shift, arr_reset, busy, done, aborted;

   yconf_loader_if #(.W(W)) bus ();

   yconf_loader #(
      .BLOCKWIDTH (W),
      .BLOCKHEIGHT(H),
      .CBITS      (CB),
      .RELEASE    (REL)
   ) dut (
      .confclk    (confclk),
      .reset      (reset),
      .start      (start),
      .swap       (swap),
      .abort      (abort),
      .strm       (bus),
      .arr_cbit   (arr_cbit),
      .arr_shift  (arr_shift),
      .arr_cbitret(arr_cbitret),
      .arr_reset  (arr_reset),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted)
   );

   always #5 confclk = ~confclk;

   // Array model: one shift chain per column, new bits enter at the top
   logic [TOT*W-1:0] chain = '0;
   assign arr_cbitret = chain[TOT*W-1 -: W];

   int total = 0;
   int bad = 0;
   int shift_cnt = 0;
   int done_cnt = 0;
   int ov_cnt = 0;
   logic [W-1:0] outq[$];

   always @(posedge confclk) begin
      if (arr_shift) begin
         chain <= {chain[TOT*W-W-1:0], arr_cbit};
         shift_cnt++;
      end
      if (done) done_cnt++;
      if (bus.out_valid) ov_cnt++;
      if (bus.out_valid && bus.out_ready) outq.push_back(bus.out_data);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge confclk);
      #2;
   endtask

   task automatic send(input logic [W-1:0] d);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      #1;
      while (!bus.in_ready && n < 40) begin
         tick();
         n++;
      end
      chk("send_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_start(input logic sw);
      start = 1'b1;
      swap  = sw;
      tick();
      start = 1'b0;
      swap  = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n;
      n = 0;
      while (!done && n < lim) begin
         tick();
         n++;
      end
      chk("done_seen", done, 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_arr_reset"}, arr_reset, 0);
      chk({tag, "_arr_shift"}, arr_shift, 0);
      chk({tag, "_arr_cbit"}, arr_cbit, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_out_data"}, bus.out_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_aborted"}, aborted, 0);
   endtask

   initial begin
      int s0;
      int d0;
      int rc;
      int n;
      logic [W-1:0] w;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      tick();
      tick();
      chk_reset_vals("rst");
      reset = 1'b1;
      tick();

      // Mode 0, six back-to-back beats
      s0 = shift_cnt;
      do_start(1'b0);
      chk("t1_busy", busy, 1);
      chk("t1_arr_reset", arr_reset, 1);
      for (int i = 1; i <= TOT; i++) begin
         send(W'(i));
         chk("t1_shift", arr_shift, 1);
         chk("t1_cbit", arr_cbit, i);
      end
      rc = 0;
      n = 0;
      while (!done && n < 30) begin
         if (arr_reset) rc++;
         tick();
         n++;
      end
      chk("t1_done", done, 1);
      chk("t1_rst_cycles", rc, 6);
      chk("t1_release", arr_reset, 0);
      chk("t1_idle", busy, 0);
      tick();
      chk("t1_done_pulse", done, 0);
      chk("t1_shifts", shift_cnt - s0, TOT);
      chk("t1_no_out", ov_cnt, 0);

      // Mode 1 readback of the previous configuration
      bus.out_ready = 1'b1;
      outq.delete();
      do_start(1'b1);
      for (int i = 0; i < TOT; i++) send(4'hF);
      wait_done(60);
      tick();
      chk("t2_nout", outq.size(), TOT);
      for (int i = 0; i < TOT; i++) begin
         w = (i < outq.size()) ? outq[i] : 4'hx;
         chk("t2_word", w, i + 1);
      end

      // Mode 1 with a sink stall after the first word
      bus.out_ready = 1'b0;
      outq.delete();
      do_start(1'b1);
      send(4'h3);
      tick();
      chk("t3_ov", bus.out_valid, 1);
      for (int k = 0; k < 5; k++) begin
         chk("t3_stall_ready", bus.in_ready, 0);
         chk("t3_stall_shift", arr_shift, 0);
         chk("t3_stall_data", bus.out_data, 4'hF);
         tick();
      end
      bus.out_ready = 1'b1;
      send(4'h5);
      send(4'h9);
      send(4'hC);
      send(4'h6);
      send(4'hA);
      wait_done(60);
      tick();
      chk("t3_nout", outq.size(), TOT);
      for (int i = 0; i < TOT; i++) begin
         w = (i < outq.size()) ? outq[i] : 4'hx;
         chk("t3_word", w, 4'hF);
      end

      // Abort on the cycle a third beat is offered
      s0 = shift_cnt;
      d0 = done_cnt;
      do_start(1'b0);
      send(4'h1);
      send(4'h2);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'h3;
      abort = 1'b1;
      #1;
      chk("t4_ready_blocked", bus.in_ready, 0);
      tick();
      abort = 1'b0;
      bus.in_valid = 1'b0;
      chk("t4_shift", arr_shift, 0);
      chk("t4_busy", busy, 1);
      chk("t4_arr_reset", arr_reset, 1);
      chk("t4_aborted_early", aborted, 0);
      tick();
      chk("t4_aborted", aborted, 1);
      chk("t4_idle", busy, 0);
      chk("t4_arr_reset_held", arr_reset, 1);
      tick();
      chk("t4_aborted_pulse", aborted, 0);
      chk("t4_arr_reset_still", arr_reset, 1);
      chk("t4_shifts", shift_cnt - s0, 2);
      chk("t4_no_done", done_cnt - d0, 0);

      // Reset in the middle of a shift
      do_start(1'b0);
      send(4'h7);
      chk("t5_mid_shift", arr_shift, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk_reset_vals("t5");
      s0 = shift_cnt;
      d0 = done_cnt;
      do_start(1'b0);
      for (int i = 0; i < TOT; i++) send(W'(i + 8));
      wait_done(60);
      tick();
      chk("t5_shifts", shift_cnt - s0, TOT);
      chk("t5_done_cnt", done_cnt - d0, 1);
      chk("t5_release", arr_reset, 0);

      // Start while in HOLD is ignored
      d0 = done_cnt;
      s0 = shift_cnt;
      do_start(1'b0);
      for (int i = 1; i <= TOT; i++) send(W'(i));
      tick();
      tick();
      chk("t6_hold_busy", busy, 1);
      chk("t6_hold_arr_reset", arr_reset, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_busy", busy, 1);
      chk("t6_no_ready", bus.in_ready, 0);
      for (int k = 0; k < 15; k++) tick();
      chk("t6_one_done", done_cnt - d0, 1);
      chk("t6_idle", busy, 0);
      chk("t6_shifts", shift_cnt - s0, TOT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
